// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg: shared constants, default opcodes and data-register selection for the JTAG TAP register block.
package jtag_tap_pkg;
   localparam logic [1:0] IR_CAPTURE       = 2'b01;
   localparam logic [3:0] DEF_IDCODE_INSTR = 4'h1;
   localparam logic [3:0] DEF_USER_INSTR   = 4'h8;
   typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_USER} dr_sel_t;
   // All-ones always means BYPASS, even if an opcode parameter collides with it.
   function automatic dr_sel_t dr_select(input logic idcode_hit, input logic user_hit, input logic all_ones);
      return all_ones ? SEL_BYPASS : idcode_hit ? SEL_IDCODE : user_hit ? SEL_USER : SEL_BYPASS;
   endfunction
endpackage

// File: rtl/jtag_shift_reg.sv
// jtag_shift_reg: capture/shift register (LSB first) with a parallel update stage.
module jtag_shift_reg #(
   parameter int               WIDTH        = 4,
   parameter logic [WIDTH-1:0] RESET_VAL    = '0,
   parameter logic [WIDTH-1:0] UPDATE_RESET = '0
) (
   input  logic             tck,
   input  logic             trst,
   input  logic             capture,
   input  logic             shift,
   input  logic             update,
   input  logic             clear_update,
   input  logic             tdi,
   input  logic [WIDTH-1:0] capture_val,
   output logic [WIDTH-1:0] sr,
   output logic [WIDTH-1:0] upd
);
   logic [WIDTH-1:0] shifted;
   generate
      if (WIDTH == 1) begin : g_one
         assign shifted = tdi;
      end else begin : g_wide
         assign shifted = {tdi, sr[WIDTH-1:1]};
      end
   endgenerate
   always_ff @(posedge tck) begin
      if (!trst) sr <= RESET_VAL;
      else if (capture) sr <= capture_val;
      else if (shift) sr <= shifted;
   end
   always_ff @(posedge tck) begin
      if (!trst || clear_update) upd <= UPDATE_RESET;
      else if (update) upd <= sr;
   end
endmodule

// File: rtl/jtag_tap_regs.sv
// jtag_tap_regs: IR, BYPASS, IDCODE and optional USER data registers behind a TAP controller.
// Define JTAG_USER_DR_EN to build the USER register; otherwise USER_INSTR selects BYPASS.
module jtag_tap_regs
   import jtag_tap_pkg::*;
#(
   parameter int                IR_LEN       = 4,
   parameter logic [31:0]       IDCODE_VALUE = 32'h1000_0001,
   parameter logic [IR_LEN-1:0] IDCODE_INSTR = IR_LEN'(DEF_IDCODE_INSTR),
   parameter logic [IR_LEN-1:0] USER_INSTR   = IR_LEN'(DEF_USER_INSTR),
   parameter int                USER_DR_LEN  = 32
) (
   input  logic                   tck,
   input  logic                   trst,
   input  logic                   tdi,
   input  logic                   state_tlr,
   input  logic                   state_capturedr,
   input  logic                   state_captureir,
   input  logic                   state_shiftdr,
   input  logic                   state_shiftir,
   input  logic                   state_updatedr,
   input  logic                   state_updateir,
   output logic                   tdo,
   output logic                   tdo_en,
   output logic [IR_LEN-1:0]      ir,
   input  logic [USER_DR_LEN-1:0] user_capture,
   output logic [USER_DR_LEN-1:0] user_update,
   output logic                   user_update_stb
);
   localparam logic [IR_LEN-1:0] IR_CAP = IR_LEN'(IR_CAPTURE);
   logic [IR_LEN-1:0] ir_sr;
   logic [31:0] idcode_sr, idcode_upd;
   logic cap_ir, sh_ir, up_ir, cap_dr, sh_dr, up_dr, user_hit, bypass, user_dr0, dr0;
   logic unused_ok;
   dr_sel_t sel;
   // tlr > capture > shift > update, applied separately to the IR and DR paths
   assign cap_ir = state_captureir & ~state_tlr;
   assign sh_ir  = state_shiftir & ~state_tlr & ~state_captureir;
   assign up_ir  = state_updateir & ~state_tlr & ~state_captureir & ~state_shiftir;
   assign cap_dr = state_capturedr & ~state_tlr;
   assign sh_dr  = state_shiftdr & ~state_tlr & ~state_capturedr;
   assign up_dr  = state_updatedr & ~state_tlr & ~state_capturedr & ~state_shiftdr;
`ifdef JTAG_USER_DR_EN
   assign user_hit = ir == USER_INSTR;
`else
   assign user_hit = 1'b0;
`endif
   assign sel = dr_select(ir == IDCODE_INSTR, user_hit, &ir);
   jtag_shift_reg #(.WIDTH(IR_LEN), .RESET_VAL('0), .UPDATE_RESET(IDCODE_INSTR)) u_ir (
      .tck(tck), .trst(trst), .capture(cap_ir), .shift(sh_ir), .update(up_ir),
      .clear_update(state_tlr), .tdi(tdi), .capture_val(IR_CAP), .sr(ir_sr), .upd(ir)
   );
   jtag_shift_reg #(.WIDTH(32), .RESET_VAL(IDCODE_VALUE), .UPDATE_RESET('0)) u_idcode (
      .tck(tck), .trst(trst), .capture(cap_dr && sel == SEL_IDCODE), .shift(sh_dr && sel == SEL_IDCODE),
      .update(1'b0), .clear_update(1'b0), .tdi(tdi), .capture_val(IDCODE_VALUE),
      .sr(idcode_sr), .upd(idcode_upd)
   );
   always_ff @(posedge tck) begin
      if (!trst) bypass <= 1'b0;
      else if (cap_dr && sel == SEL_BYPASS) bypass <= 1'b0;
      else if (sh_dr && sel == SEL_BYPASS) bypass <= tdi;
   end
`ifdef JTAG_USER_DR_EN
   logic [USER_DR_LEN-1:0] user_sr;
   jtag_shift_reg #(.WIDTH(USER_DR_LEN), .RESET_VAL('0), .UPDATE_RESET('0)) u_user (
      .tck(tck), .trst(trst), .capture(cap_dr && sel == SEL_USER), .shift(sh_dr && sel == SEL_USER),
      .update(up_dr && sel == SEL_USER), .clear_update(1'b0), .tdi(tdi), .capture_val(user_capture),
      .sr(user_sr), .upd(user_update)
   );
   always_ff @(posedge tck) user_update_stb <= trst & up_dr & (sel == SEL_USER);
   assign user_dr0 = user_sr[0];
   assign unused_ok = ^{idcode_sr, idcode_upd};
`else
   assign user_update = '0;
   assign user_update_stb = 1'b0;
   assign user_dr0 = 1'b0;
   assign unused_ok = ^{idcode_sr, idcode_upd, user_capture};
`endif
   assign dr0 = sel == SEL_IDCODE ? idcode_sr[0] : sel == SEL_USER ? user_dr0 : bypass;
   assign tdo = state_shiftir ? ir_sr[0] : state_shiftdr ? dr0 : 1'b0;
   assign tdo_en = state_shiftir | state_shiftdr;
endmodule

// File: tb/tb_jtag_tap_regs.sv
// tb_jtag_tap_regs: scoreboard bench driving TAP state strobes and checking tdo, ir and the USER interface.
module tb_jtag_tap_regs;
   localparam logic [6:0] IDLE = 7'h00, TLR = 7'h40, CDR = 7'h20, CIR = 7'h10,
                          SDR = 7'h08, SIR = 7'h04, UDR = 7'h02, UIR = 7'h01;
   logic tck = 1'b0, trst = 1'b0, tdi = 1'b0;
   logic [6:0] st = IDLE;
   logic tdo, tdo_en, user_update_stb;
   logic [3:0] ir;
   logic [31:0] user_capture = 32'h0, user_update;
   logic exp_q[$];
   int n_vec = 0, n_err = 0;
   always #5 tck = ~tck;
   jtag_tap_regs dut (
      .tck(tck), .trst(trst), .tdi(tdi),
      .state_tlr(st[6]), .state_capturedr(st[5]), .state_captureir(st[4]), .state_shiftdr(st[3]),
      .state_shiftir(st[2]), .state_updatedr(st[1]), .state_updateir(st[0]),
      .tdo(tdo), .tdo_en(tdo_en), .ir(ir),
      .user_capture(user_capture), .user_update(user_update), .user_update_stb(user_update_stb)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic cyc(input logic [6:0] s, input logic d);
      st = s;
      tdi = d;
      #1;
      if ((s & (SDR | SIR)) != 0 && exp_q.size() > 0) chk("tdo", tdo, exp_q.pop_front());
      if ((s & (SDR | SIR)) != 0) chk("tdo_en", tdo_en, 1'b1);
      @(posedge tck);
      #1;
   endtask
   task automatic shift(input logic is_ir, input int n, input logic [63:0] din, input logic [63:0] exp);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(exp[i]);
         cyc(is_ir ? SIR : SDR, din[i]);
      end
   endtask
   task automatic load_ir(input logic [3:0] v);
      cyc(CIR, 1'b0);
      shift(1'b1, 4, 64'(v), 64'h1);
      cyc(UIR, 1'b0);
      chk("ir_load", ir, v);
   endtask
   initial begin
      logic [63:0] din;
      cyc(IDLE, 1'b0);
      cyc(IDLE, 1'b0);
      trst = 1'b1;
      chk("rst_ir", ir, 4'h1);
      chk("rst_tdo", tdo, 1'b0);
      chk("rst_tdo_en", tdo_en, 1'b0);
      chk("rst_uupd", user_update, 32'h0);
      chk("rst_stb", user_update_stb, 1'b0);
      cyc(TLR, 1'b0);
      cyc(IDLE, 1'b0);
      cyc(CDR, 1'b0);
      shift(1'b0, 32, 64'h0, 64'h1000_0001);
      cyc(IDLE, 1'b0);
      chk("idle_tdo_en", tdo_en, 1'b0);
      load_ir(4'hF);
      cyc(CDR, 1'b0);
      shift(1'b0, 4, 64'b1101, 64'b1010);
      user_capture = 32'hDEAD_BEEF;
      load_ir(4'h8);
      din = 64'h1234_5678;
      cyc(CDR, 1'b0);
`ifdef JTAG_USER_DR_EN
      shift(1'b0, 32, din, 64'hDEAD_BEEF);
`else
      shift(1'b0, 32, din, din << 1);
`endif
      cyc(UDR, 1'b0);
`ifdef JTAG_USER_DR_EN
      chk("uupd", user_update, 32'h1234_5678);
      chk("stb_hi", user_update_stb, 1'b1);
`else
      chk("uupd", user_update, 32'h0);
      chk("stb_hi", user_update_stb, 1'b0);
`endif
      cyc(IDLE, 1'b0);
      chk("stb_lo", user_update_stb, 1'b0);
      load_ir(4'h3);
      din = 64'h5A;
      cyc(CDR, 1'b0);
      shift(1'b0, 8, din, din << 1);
      cyc(CIR, 1'b0);
      shift(1'b1, 4, 64'h6, 64'h1);
      for (int i = 0; i < 5; i++) cyc(TLR, 1'b0);
      chk("tlr_ir", ir, 4'h1);
`ifdef JTAG_USER_DR_EN
      chk("tlr_uupd", user_update, 32'h1234_5678);
`else
      chk("tlr_uupd", user_update, 32'h0);
`endif
      cyc(IDLE, 1'b0);
      load_ir(4'h8);
      user_capture = 32'hCAFE_F00D;
      cyc(CDR, 1'b0);
`ifdef JTAG_USER_DR_EN
      shift(1'b0, 10, 64'h3FF, 64'hCAFE_F00D);
`else
      shift(1'b0, 10, 64'h3FF, 64'h3FF << 1);
`endif
      trst = 1'b0;
      cyc(SDR, 1'b1);
      trst = 1'b1;
      st = IDLE;
      #1;
      chk("mid_rst_ir", ir, 4'h1);
      chk("mid_rst_tdo", tdo, 1'b0);
      chk("mid_rst_tdo_en", tdo_en, 1'b0);
      chk("mid_rst_uupd", user_update, 32'h0);
      chk("mid_rst_stb", user_update_stb, 1'b0);
      cyc(IDLE, 1'b0);
      chk("post_rst_stb", user_update_stb, 1'b0);
      shift(1'b0, 32, 64'h0, 64'h1000_0001);
      cyc(IDLE, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/jtag_tap_regs.md
Name: jtag_tap_regs

Overview:
- Downstream of the TAP state machine. Consumes its decoded state strobes, tdi and tck.
- Implements the Instruction Register (IR), BYPASS, IDCODE and one optional USER data register.
- Drives tdo / tdo_en toward the pad logic.
- Exposes the current instruction, plus a USER update interface, to core-side JTAG consumers.

Parameters:
- IR_LEN, 4, instruction register width (min 2).
- IDCODE_VALUE, 32'h1000_0001, captured into IDCODE DR; bit 0 must be 1.
- IDCODE_INSTR, 4'h1, IR opcode selecting IDCODE (IR_LEN bits).
- USER_INSTR, 4'h8, IR opcode selecting USER DR (IR_LEN bits).
- USER_DR_LEN, 32, USER data register width (min 1).

Ports:
- tck  in  1  JTAG clock; all state changes on rising edge.
- trst  in  1  synchronous active-low reset, sampled on tck rising edge.
- tdi  in  1  serial data in.
- state_tlr  in  1  TAP in Test-Logic-Reset.
- state_capturedr  in  1  TAP in Capture-DR.
- state_captureir  in  1  TAP in Capture-IR.
- state_shiftdr  in  1  TAP in Shift-DR.
- state_shiftir  in  1  TAP in Shift-IR.
- state_updatedr  in  1  TAP in Update-DR.
- state_updateir  in  1  TAP in Update-IR.
- tdo  out  1  serial data out (LSB of active shift path).
- tdo_en  out  1  high while in Shift-IR or Shift-DR.
- ir  out  IR_LEN  current latched instruction.
- user_capture  in  USER_DR_LEN  value loaded into USER shift reg at Capture-DR.
- user_update  out  USER_DR_LEN  USER value latched at Update-DR.
- user_update_stb  out  1  one-tck pulse marking the user_update load.

Behaviour:
- Reset (trst low at a rising edge):
  - ir <= IDCODE_INSTR; IR shift reg <= 0; bypass <= 0; IDCODE shift reg <= IDCODE_VALUE.
  - USER shift reg <= 0; user_update <= 0; user_update_stb <= 0.
  - Reset has priority over every state strobe, including mid-shift.
- state_tlr high at a rising edge: ir <= IDCODE_INSTR; user_update is unchanged.
- Register selection (combinational from ir):
  - ir == IDCODE_INSTR -> IDCODE.
  - ir == USER_INSTR -> USER.
  - all-ones and every other opcode -> BYPASS.
- Capture-IR: IR shift reg <= {(IR_LEN-2) zeros, 2'b01}.
- Capture-DR (selected register only):
  - BYPASS <= 0.
  - IDCODE <= IDCODE_VALUE.
  - USER <= user_capture.
- Shifting is LSB first: reg <= {tdi, reg[N-1:1]}.
  - Shift-IR: applies to the IR shift reg.
  - Shift-DR: applies to the selected DR only; BYPASS is a 1-bit reg <= tdi.
  - Non-selected DRs hold.
- Update-IR: ir <= IR shift reg. The new selection takes effect from the next cycle.
- Update-DR with USER selected:
  - user_update <= USER shift reg.
  - user_update_stb high for exactly the following cycle.
  - No effect for IDCODE or BYPASS.
- tdo (combinational mux of registered bits):
  - Shift-IR -> IR shift reg[0].
  - Shift-DR -> selected DR[0].
  - else 0.
- tdo_en = state_shiftir | state_shiftdr. No internal negedge retiming; pad logic owns that.
- Latency: the first tdi bit shifted in appears on tdo after N rising edges in Shift state (N = register length). BYPASS gives 1-cycle latency.
- If more than one strobe is high at once (illegal), priority is tlr > capture > shift > update; IR and DR actions are independent.
- A Shift-IR/DR sequence that is aborted (TLR entered before Update) leaves ir and user_update unmodified.

Optional Feature:
- JTAG_USER_DR_EN defined: USER register, user_capture, user_update and user_update_stb present as above.
- Undefined:
  - USER logic is removed; USER_INSTR decodes to BYPASS.
  - user_update is tied 0 and user_update_stb is tied 0.
  - user_capture is ignored.
  - Ports are retained for a stable interface.

Decomposition:
- Package jtag_tap_pkg holds:
  - IR capture pattern constant 2'b01;
  - default opcodes IDCODE_INSTR and USER_INSTR;
  - the BYPASS all-ones rule;
  - a register-select enum {SEL_BYPASS, SEL_IDCODE, SEL_USER}.
- One sub-module: jtag_shift_reg, a parameterised capture/shift/update register (WIDTH, RESET_VAL). It is instantiated for IR, IDCODE and USER; BYPASS is inline.

Test Plan:
- Reset, TLR->RTI->Shift-DR, shift 32 bits of tdi=0 -> tdo LSB-first is 32'h1000_0001; tdo_en high throughout.
- Capture-IR, shift IR_LEN bits -> tdo reads 4'b0001 LSB first (1,0,0,0).
- Load IR=4'hF (BYPASS), shift DR with tdi pattern 1,0,1,1 -> tdo is 0,1,0,1 (one-cycle delay, first bit 0 from capture).
- Load IR=USER_INSTR, user_capture=32'hDEAD_BEEF, shift in 32'h1234_5678, Update-DR:
  - tdo streams DEAD_BEEF LSB first;
  - user_update=32'h1234_5678;
  - user_update_stb pulses for one cycle.
- Load IR=4'h3 (undefined), shift DR -> BYPASS behaviour; then 5 tck with tms=1 (TLR) -> ir returns to 4'h1.
- Assert trst low mid Shift-DR of USER -> next cycle all outputs at reset values; user_update stays 0, no strobe.
